sdram_rr_scheduler: RTL and testbench

- Shares the single SDRAM controller command port among 3 client requesters using round-robin priority.
- Schedules periodic auto-refresh from an internal interval timer; a pending refresh takes precedence at every arbitration point.
- Sits between the client masters (video fetch, CPU, DMA) and the SDRAM controller; ack/ref_req select the command-port mux and the controller's refresh path.

---
 rtl/sdram_rr_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_sdram_rr_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sdram_rr_scheduler
// Purpose  : Shares one SDRAM controller command port among three clients
//            (video fetch, CPU, DMA) with round-robin priority, and inserts
//            periodic auto-refresh from an internal interval timer. A pending
//            refresh wins at every arbitration point (IDLE).
// Ports    : clk      - system clock, rising edge
//            rst      - asynchronous active-high reset
//            req[2:0] - client requests, held while a client wants the port
//            ack[2:0] - one-hot grant, client i owns the port this cycle
//            ref_req  - refresh request to controller, held until ref_ack
//            ref_ack  - one-cycle refresh-complete pulse from controller
//            owner    - current owner index, 3 = refresh or idle
//            busy     - high in GRANT or REFRESH
//            ref_miss - sticky, timer expired while a refresh was pending
// Options  : SDRAM_RR_HOLD_LIMIT_EN - when defined, an owner is forced off
//            the port after MAX_HOLD cycles if anyone else is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_rr_scheduler #(
    parameter int REF_INTERVAL = 780,
    parameter int MAX_HOLD     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] ack,
    output logic       ref_req,
    input  logic       ref_ack,
    output logic [1:0] owner,
    output logic       busy,
    output logic       ref_miss
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_REFRESH = 2'd2
    } state_t;

    localparam logic [15:0] c_timer_reload = 16'(REF_INTERVAL - 1);
    localparam logic [1:0]  c_owner_none   = 2'd3;

    if (REF_INTERVAL < 16 || REF_INTERVAL > 65535 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("sdram_rr_scheduler: parameter out of legal range");
    end

    state_t      state_q,     state_d;
    logic [1:0]  owner_q,     owner_d;
    logic [1:0]  rr_ptr_q,    rr_ptr_d;
    logic [15:0] ref_timer_q, ref_timer_d;
    logic        ref_pend_q,  ref_pend_d;
    logic        ref_miss_q,  ref_miss_d;

    logic [2:0]  owner_mask;
    logic        timer_expire;
    logic        pend_clear;
    logic [1:0]  cand_a;
    logic [1:0]  cand_b;
    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic        preempt;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign owner_mask = 3'b001 << owner_q;

    // ------------------------------------------------------------------
    // Refresh timer. A ref_ack landing on the expiry cycle retires the old
    // refresh and the new one is latched at the same time, so no miss.
    // ------------------------------------------------------------------
    assign timer_expire = (ref_timer_q == 16'd0);
    assign pend_clear   = (state_q == ST_REFRESH) && ref_ack;

    always_comb begin
        ref_timer_d = timer_expire ? c_timer_reload : ref_timer_q - 16'd1;
        ref_pend_d  = ref_pend_q;
        if (pend_clear) begin
            ref_pend_d = 1'b0;
        end
        if (timer_expire) begin
            ref_pend_d = 1'b1;
        end
        ref_miss_d = ref_miss_q | (timer_expire & ref_pend_q & ~pend_clear);
    end

    // ------------------------------------------------------------------
    // Round-robin pick: search order starts just after the last grantee,
    // so the previous owner is always considered last.
    // ------------------------------------------------------------------
    always_comb begin
        cand_a     = next_idx(rr_ptr_q);
        cand_b     = next_idx(cand_a);
        pick_valid = 1'b1;
        pick_idx   = rr_ptr_q;
        if (req[cand_a]) begin
            pick_idx = cand_a;
        end else if (req[cand_b]) begin
            pick_idx = cand_b;
        end else if (req[rr_ptr_q]) begin
            pick_idx = rr_ptr_q;
        end else begin
            pick_valid = 1'b0;
        end
    end

`ifdef SDRAM_RR_HOLD_LIMIT_EN
    localparam logic [7:0] c_hold_limit = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;

    // Someone else is waiting: a pending refresh or any non-owner request.
    assign preempt = (hold_cnt_q >= c_hold_limit) &&
                     (ref_pend_q || ((req & ~owner_mask) != 3'b000));

    always_comb begin
        hold_cnt_d = 8'd0;
        if (state_q == ST_GRANT && !preempt && ((req & owner_mask) != 3'b000)) begin
            hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (ref_pend_q) begin
                    state_d = ST_REFRESH;
                end else if (pick_valid) begin
                    state_d  = ST_GRANT;
                    owner_d  = pick_idx;
                    rr_ptr_d = pick_idx;
                end
            end
            ST_GRANT: begin
                if (((req & owner_mask) == 3'b000) || preempt) begin
                    state_d = ST_IDLE;
                    owner_d = c_owner_none;
                end
            end
            ST_REFRESH: begin
                if (ref_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = c_owner_none;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= c_owner_none;
            rr_ptr_q    <= 2'd2;
            ref_timer_q <= c_timer_reload;
            ref_pend_q  <= 1'b0;
            ref_miss_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            ref_timer_q <= ref_timer_d;
            ref_pend_q  <= ref_pend_d;
            ref_miss_q  <= ref_miss_d;
        end
    end

    // Outputs decode only registered state; req never reaches ack directly.
    assign ack      = (state_q == ST_GRANT) ? owner_mask : 3'b000;
    assign ref_req  = (state_q == ST_REFRESH);
    assign owner    = owner_q;
    assign busy     = (state_q != ST_IDLE);
    assign ref_miss = ref_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_rr_scheduler
// Purpose  : Directed-vector bench for sdram_rr_scheduler. Stimulus pushes
//            the hand-computed output state expected after each clock edge;
//            a monitor pops and compares on the falling edge, or right away
//            for asynchronous reset checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_rr_scheduler;

    localparam int REF_INTERVAL = 16;
    localparam int MAX_HOLD     = 4;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] ack;
    logic       ref_req;
    logic       ref_ack;
    logic [1:0] owner;
    logic       busy;
    logic       ref_miss;

    sdram_rr_scheduler #(
        .REF_INTERVAL (REF_INTERVAL),
        .MAX_HOLD     (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ack      (ack),
        .ref_req  (ref_req),
        .ref_ack  (ref_ack),
        .owner    (owner),
        .busy     (busy),
        .ref_miss (ref_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ack[2:0], ref_req, owner[1:0], busy, ref_miss}
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    event       mon_ev;

    always @(negedge clk) -> mon_ev;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] e;
        logic [7:0] g;
        string      nm;
        forever begin
            @(mon_ev);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                g  = {ack, ref_req, owner, busy, ref_miss};
                n_checks++;
                if (g === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got ack=%b ref_req=%b owner=%0d busy=%b ref_miss=%b, expected ack=%b ref_req=%b owner=%0d busy=%b ref_miss=%b",
                             nm, g[7:5], g[4], g[3:2], g[1], g[0], e[7:5], e[4], e[3:2], e[1], e[0]);
                end
                n_checks++;
                if ($onehot0(ack)) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s_onehot: got ack=%b, expected at most one bit set", nm, ack);
                end
            end
        end
    end

    // Owner and busy follow directly from the expected grant/refresh state.
    task automatic push_exp(input logic [2:0] e_ack, input logic e_rr, input logic e_miss, input string nm);
        logic [1:0] e_owner;
        logic       e_busy;
        case (e_ack)
            3'b001:  e_owner = 2'd0;
            3'b010:  e_owner = 2'd1;
            3'b100:  e_owner = 2'd2;
            default: e_owner = 2'd3;
        endcase
        e_busy = (e_ack != 3'b000) || e_rr;
        exp_q.push_back({e_ack, e_rr, e_owner, e_busy, e_miss});
        name_q.push_back(nm);
    endtask

    // One clock: drive inputs, then expect the outputs after the edge.
    task automatic cyc(input logic [2:0] r, input logic ra, input logic [2:0] e_ack,
                       input logic e_rr, input logic e_miss, input string nm);
        req     = r;
        ref_ack = ra;
        @(posedge clk);
        push_exp(e_ack, e_rr, e_miss, nm);
        @(negedge clk);
        ref_ack = 1'b0;
    endtask

    // Asynchronous reset with an immediate check, well clear of any edge.
    task automatic do_reset(input string nm);
        #2;
        rst     = 1'b1;
        req     = 3'b000;
        ref_ack = 1'b0;
        #1;
        push_exp(3'b000, 1'b0, 1'b0, nm);
        -> mon_ev;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic e_miss, input string nm);
        for (int i = 0; i < n; i++) cyc(3'b000, 1'b0, 3'b000, 1'b0, e_miss, nm);
    endtask

    task automatic ref_cycles(input int n, input logic e_miss, input string nm);
        for (int i = 0; i < n; i++) cyc(3'b000, 1'b0, 3'b000, 1'b1, e_miss, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, expected end of stimulus");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst     = 1'b0;
        req     = 3'b000;
        ref_ack = 1'b0;
        @(negedge clk);

        // A: round-robin rotation and one idle cycle between grants
        do_reset("a_reset");
        cyc(3'b111, 1'b0, 3'b001, 1'b0, 1'b0, "a_g0");
        cyc(3'b111, 1'b0, 3'b001, 1'b0, 1'b0, "a_g0_hold");
        cyc(3'b110, 1'b0, 3'b000, 1'b0, 1'b0, "a_idle0");
        cyc(3'b110, 1'b0, 3'b010, 1'b0, 1'b0, "a_g1");
        cyc(3'b110, 1'b0, 3'b010, 1'b0, 1'b0, "a_g1_hold");
        cyc(3'b100, 1'b0, 3'b000, 1'b0, 1'b0, "a_idle1");
        cyc(3'b100, 1'b0, 3'b100, 1'b0, 1'b0, "a_g2");
        cyc(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "a_idle2");
        cyc(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "a_idle3");
        cyc(3'b111, 1'b0, 3'b001, 1'b0, 1'b0, "a_wrap_g0");
        cyc(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "a_idle4");
        cyc(3'b011, 1'b0, 3'b010, 1'b0, 1'b0, "a_rr_g1");
        idle_cycles(4, 1'b0, "a_idle5");
        cyc(3'b000, 1'b0, 3'b000, 1'b1, 1'b0, "a_ref");

        // B: refresh interval and ref_ack handshake
        do_reset("b_reset");
        idle_cycles(16, 1'b0, "b_idle");
        ref_cycles(5, 1'b0, "b_ref1");
        cyc(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, "b_refack1");
        idle_cycles(10, 1'b0, "b_idle2");
        cyc(3'b000, 1'b0, 3'b000, 1'b1, 1'b0, "b_ref2");
        cyc(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, "b_refack2");

        // C: refresh waits for the current owner, then beats client 0
        do_reset("c_reset");
`ifdef SDRAM_RR_HOLD_LIMIT_EN
        for (int i = 0; i < 16; i++) cyc(3'b100, 1'b0, 3'b100, 1'b0, 1'b0, "c_g2");
        cyc(3'b100, 1'b0, 3'b000, 1'b0, 1'b0, "c_preempt");
        cyc(3'b100, 1'b0, 3'b000, 1'b1, 1'b0, "c_ref");
        cyc(3'b100, 1'b1, 3'b000, 1'b0, 1'b0, "c_refack");
        cyc(3'b100, 1'b0, 3'b100, 1'b0, 1'b0, "c_g2_again");
        cyc(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "c_idle");
`else
        for (int i = 0; i < 19; i++) cyc(3'b100, 1'b0, 3'b100, 1'b0, 1'b0, "c_g2");
        cyc(3'b100, 1'b1, 3'b100, 1'b0, 1'b0, "c_stray_ack");
        for (int i = 0; i < 11; i++) cyc(3'b100, 1'b0, 3'b100, 1'b0, 1'b0, "c_g2_late");
        for (int i = 0; i < 3; i++)  cyc(3'b100, 1'b0, 3'b100, 1'b0, 1'b1, "c_g2_miss");
        for (int i = 0; i < 6; i++)  cyc(3'b101, 1'b0, 3'b100, 1'b0, 1'b1, "c_g2_contend");
        cyc(3'b001, 1'b0, 3'b000, 1'b0, 1'b1, "c_release");
        cyc(3'b001, 1'b0, 3'b000, 1'b1, 1'b1, "c_ref_first");
        cyc(3'b001, 1'b1, 3'b000, 1'b0, 1'b1, "c_refack");
        cyc(3'b001, 1'b0, 3'b001, 1'b0, 1'b1, "c_g0");
        cyc(3'b000, 1'b0, 3'b000, 1'b0, 1'b1, "c_idle");
`endif

        // D: ref_ack on the expiry cycle keeps ref_pend, no miss
        do_reset("d_reset");
        idle_cycles(16, 1'b0, "d_idle");
        ref_cycles(15, 1'b0, "d_ref");
        cyc(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, "d_ack_at_expiry");
        cyc(3'b000, 1'b0, 3'b000, 1'b1, 1'b0, "d_ref_again");
        cyc(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, "d_refack");

        // E: withheld ref_ack sets sticky ref_miss; only reset clears it
        do_reset("e_reset");
        idle_cycles(16, 1'b0, "e_idle");
        ref_cycles(15, 1'b0, "e_ref");
        ref_cycles(5, 1'b1, "e_ref_miss");
        cyc(3'b000, 1'b1, 3'b000, 1'b0, 1'b1, "e_ack_late");
        idle_cycles(3, 1'b1, "e_miss_sticky");
        do_reset("e_miss_cleared");

        // F: hold limit with two contending clients
        do_reset("f_reset");
`ifdef SDRAM_RR_HOLD_LIMIT_EN
        for (int i = 0; i < 4; i++) cyc(3'b011, 1'b0, 3'b001, 1'b0, 1'b0, "f_g0");
        cyc(3'b011, 1'b0, 3'b000, 1'b0, 1'b0, "f_forced_idle0");
        for (int i = 0; i < 4; i++) cyc(3'b011, 1'b0, 3'b010, 1'b0, 1'b0, "f_g1");
        cyc(3'b011, 1'b0, 3'b000, 1'b0, 1'b0, "f_forced_idle1");
        for (int i = 0; i < 4; i++) cyc(3'b011, 1'b0, 3'b001, 1'b0, 1'b0, "f_g0_again");
        cyc(3'b011, 1'b0, 3'b000, 1'b0, 1'b0, "f_forced_idle2");
        cyc(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "f_idle");
`else
        for (int i = 0; i < 20; i++) cyc(3'b011, 1'b0, 3'b001, 1'b0, 1'b0, "f_keep_g0");
`endif

        // G: asynchronous reset in GRANT and in REFRESH
        do_reset("g_reset");
        cyc(3'b111, 1'b0, 3'b001, 1'b0, 1'b0, "g_g0");
        cyc(3'b111, 1'b0, 3'b001, 1'b0, 1'b0, "g_g0_hold");
        do_reset("g_rst_in_grant");
        cyc(3'b111, 1'b0, 3'b001, 1'b0, 1'b0, "g_first_after_rst");
        cyc(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "g_idle");
        idle_cycles(14, 1'b0, "g_idle_wait");
        ref_cycles(2, 1'b0, "g_ref");
        do_reset("g_rst_in_refresh");
        cyc(3'b111, 1'b0, 3'b001, 1'b0, 1'b0, "g_first_after_rst2");

        #2;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
